// File: rtl/fir_pkg.sv
// Shared types and width helpers for the parameterised FIR filter.
package fir_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_MAC  = 2'd2,
        ST_DONE = 2'd3
    } fir_state_t;

    function automatic int fir_clog2(input int value);
        int res;
        res = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) res = i + 1;
        end
        return res;
    endfunction

    // Wide enough that MAX_TAPS full-scale products can never overflow.
    function automatic int fir_acc_w(input int data_w, input int coeff_w, input int max_taps);
        return data_w + coeff_w + fir_clog2(max_taps);
    endfunction

endpackage

// File: rtl/fir_coeff_ram.sv
// Coefficient store: one synchronous write port, one asynchronous read port.
module fir_coeff_ram
    import fir_pkg::*;
#(
    parameter int COEFF_W  = 16,
    parameter int MAX_TAPS = 40,
    parameter int ADDR_W   = fir_clog2(MAX_TAPS)
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      wr_en,
    input  logic [ADDR_W-1:0]         wr_addr,
    input  logic signed [COEFF_W-1:0] wr_data,
    input  logic [ADDR_W-1:0]         rd_addr,
    output logic signed [COEFF_W-1:0] rd_data
);

    logic signed [COEFF_W-1:0] mem [MAX_TAPS];

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < MAX_TAPS; k++) mem[k] <= '0;
        end else if (wr_en && (32'(wr_addr) < MAX_TAPS)) begin
            mem[wr_addr] <= wr_data;
        end
    end

    assign rd_data = mem[rd_addr];

endmodule

// File: rtl/param_fir_filter.sv
// Sequential-MAC FIR filter, one tap per cycle, with a run-time coefficient load mode.
// Build option: define FIR_SAT_EN to saturate the output instead of wrapping it.
//
// state | meaning
// IDLE  | waiting for a sample strobe or a coefficient-load request
// LOAD  | coefficient writes accepted while the update flag is held
// MAC   | accumulating x[k]*coeff[k], one tap per cycle
// DONE  | result registered to the output, valid pulsed
module param_fir_filter
    import fir_pkg::*;
#(
    parameter int DATA_W    = 3,
    parameter int COEFF_W   = 16,
    parameter int MAX_TAPS  = 40,
    parameter int OUT_W     = 16,
    parameter int OUT_SHIFT = 0
) (
    input  logic                                iClk_12M,
    input  logic                                iRst,
    input  logic                                iEnSample,
    input  logic signed [DATA_W-1:0]            iFirIn,
    input  logic                                iCoeffUpdateFlag,
    input  logic                                iCoeffWrEn,
    input  logic [fir_clog2(MAX_TAPS)-1:0]      iCoeffAddr,
    input  logic signed [COEFF_W-1:0]           iCoeffData,
    input  logic [fir_clog2(MAX_TAPS+1)-1:0]    iNumOfCoeff,
    output logic signed [OUT_W-1:0]             oFirOut,
    output logic                                oFirValid,
    output logic                                oBusy,
    output logic                                oOverrun
);

    localparam int ADDR_W = fir_clog2(MAX_TAPS);
    localparam int CNT_W  = fir_clog2(MAX_TAPS + 1);
    localparam int PROD_W = DATA_W + COEFF_W;
    localparam int ACC_W  = fir_acc_w(DATA_W, COEFF_W, MAX_TAPS);
    localparam int EXT_W  = ((ACC_W > OUT_W) ? ACC_W : OUT_W) + 1;

    localparam logic signed [EXT_W-1:0] SAT_MAX = {{(EXT_W-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
    localparam logic signed [EXT_W-1:0] SAT_MIN = {{(EXT_W-OUT_W+1){1'b1}}, {(OUT_W-1){1'b0}}};

    fir_state_t state, state_nxt;

    logic signed [DATA_W-1:0]  x_line [MAX_TAPS];
    logic signed [ACC_W-1:0]   acc;
    logic [ADDR_W-1:0]         tap_idx;
    logic [CNT_W-1:0]          n_lat;
    logic [CNT_W-1:0]          n_clamped;
    logic signed [COEFF_W-1:0] coeff_rd;
    logic signed [PROD_W-1:0]  prod;
    logic signed [ACC_W-1:0]   acc_shifted;
    logic signed [EXT_W-1:0]   acc_ext;
    logic signed [OUT_W-1:0]   out_val;
    logic                      last_tap;
    logic                      accept_sample;
    logic                      coeff_we;

    fir_coeff_ram #(
        .COEFF_W  (COEFF_W),
        .MAX_TAPS (MAX_TAPS),
        .ADDR_W   (ADDR_W)
    ) u_coeff_ram (
        .clk     (iClk_12M),
        .rst     (iRst),
        .wr_en   (coeff_we),
        .wr_addr (iCoeffAddr),
        .wr_data (iCoeffData),
        .rd_addr (tap_idx),
        .rd_data (coeff_rd)
    );

    assign coeff_we      = (state == ST_LOAD) && iCoeffWrEn;
    assign accept_sample = (state == ST_IDLE) && !iCoeffUpdateFlag && iEnSample;
    assign n_clamped     = (iNumOfCoeff > CNT_W'(MAX_TAPS)) ? CNT_W'(MAX_TAPS) : iNumOfCoeff;
    assign last_tap      = (CNT_W'(tap_idx) + CNT_W'(1)) == n_lat;
    assign prod          = x_line[tap_idx] * coeff_rd;
    assign acc_shifted   = acc >>> OUT_SHIFT;
    assign acc_ext       = {{(EXT_W-ACC_W){acc_shifted[ACC_W-1]}}, acc_shifted};

    always_comb begin
        out_val = acc_ext[OUT_W-1:0];
`ifdef FIR_SAT_EN
        if (acc_ext > SAT_MAX) begin
            out_val = SAT_MAX[OUT_W-1:0];
        end else if (acc_ext < SAT_MIN) begin
            out_val = SAT_MIN[OUT_W-1:0];
        end
`endif
    end

    always_ff @(posedge iClk_12M) begin
        if (iRst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: begin
                if (iCoeffUpdateFlag) begin
                    state_nxt = ST_LOAD;
                end else if (iEnSample) begin
                    state_nxt = (n_clamped == '0) ? ST_DONE : ST_MAC;
                end
            end
            ST_LOAD: if (!iCoeffUpdateFlag) state_nxt = ST_IDLE;
            ST_MAC:  if (last_tap) state_nxt = ST_DONE;
            ST_DONE: state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        oBusy = (state != ST_IDLE);
    end

    always_ff @(posedge iClk_12M) begin
        if (iRst) begin
            for (int k = 0; k < MAX_TAPS; k++) x_line[k] <= '0;
            acc       <= '0;
            tap_idx   <= '0;
            n_lat     <= '0;
            oFirOut   <= '0;
            oFirValid <= 1'b0;
            oOverrun  <= 1'b0;
        end else begin
            oFirValid <= 1'b0;
            oOverrun  <= 1'b0;
            if (accept_sample) begin
                for (int k = MAX_TAPS - 1; k > 0; k--) x_line[k] <= x_line[k-1];
                x_line[0] <= iFirIn;
                n_lat     <= n_clamped;
                acc       <= '0;
                tap_idx   <= '0;
            end
            if (state == ST_MAC) begin
                acc     <= acc + {{(ACC_W-PROD_W){prod[PROD_W-1]}}, prod};
                tap_idx <= tap_idx + ADDR_W'(1);
            end
            if (state == ST_DONE) begin
                oFirOut   <= out_val;
                oFirValid <= 1'b1;
            end
            // A strobe while busy is lost; flag it so the source can notice.
            if (((state == ST_MAC) || (state == ST_DONE)) && iEnSample) begin
                oOverrun <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_param_fir_filter.sv
// Bench for param_fir_filter: directed scenarios plus random traffic against a timing-aware sum model.
module tb_param_fir_filter;

    localparam int DATA_W    = 3;
    localparam int COEFF_W   = 16;
    localparam int MAX_TAPS  = 40;
    localparam int OUT_W     = 16;
    localparam int OUT_SHIFT = 0;
    localparam int ADDR_W    = 6;
    localparam int CNT_W     = 6;

    logic                      iClk_12M = 1'b0;
    logic                      iRst;
    logic                      iEnSample;
    logic signed [DATA_W-1:0]  iFirIn;
    logic                      iCoeffUpdateFlag;
    logic                      iCoeffWrEn;
    logic [ADDR_W-1:0]         iCoeffAddr;
    logic signed [COEFF_W-1:0] iCoeffData;
    logic [CNT_W-1:0]          iNumOfCoeff;
    logic signed [OUT_W-1:0]   oFirOut;
    logic                      oFirValid;
    logic                      oBusy;
    logic                      oOverrun;

    param_fir_filter #(
        .DATA_W    (DATA_W),
        .COEFF_W   (COEFF_W),
        .MAX_TAPS  (MAX_TAPS),
        .OUT_W     (OUT_W),
        .OUT_SHIFT (OUT_SHIFT)
    ) dut (
        .iClk_12M         (iClk_12M),
        .iRst             (iRst),
        .iEnSample        (iEnSample),
        .iFirIn           (iFirIn),
        .iCoeffUpdateFlag (iCoeffUpdateFlag),
        .iCoeffWrEn       (iCoeffWrEn),
        .iCoeffAddr       (iCoeffAddr),
        .iCoeffData       (iCoeffData),
        .iNumOfCoeff      (iNumOfCoeff),
        .oFirOut          (oFirOut),
        .oFirValid        (oFirValid),
        .oBusy            (oBusy),
        .oOverrun         (oOverrun)
    );

    always #5 iClk_12M = ~iClk_12M;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input longint got, input longint exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Reference: coefficient/delay arrays, sum computed at acceptance,
    // result due N+2 cycles after the strobe, busy window in between.
    longint m_coeff [MAX_TAPS];
    longint m_x     [MAX_TAPS];
    bit     m_loading;
    int     t_acc, comp_end, cyc;
    longint y_pend, m_out;
    longint got_q[$];
    int     valid_cyc_q[$];
    int     strobe_q[$];
    int     ovr_cnt;

    function automatic longint fmt_out(input longint a);
        longint s, w, half, full;
        s    = a >>> OUT_SHIFT;
        half = longint'(1) << (OUT_W - 1);
        full = longint'(1) << OUT_W;
`ifdef FIR_SAT_EN
        if (s > half - 1) return half - 1;
        if (s < -half) return -half;
        return s;
`else
        w = s & (full - 1);
        if (w >= half) w = w - full;
        return w;
`endif
    endfunction

    task automatic model_reset();
        for (int k = 0; k < MAX_TAPS; k++) begin
            m_coeff[k] = 0;
            m_x[k]     = 0;
        end
        m_loading = 0;
        t_acc     = -100;
        comp_end  = -100;
        m_out     = 0;
    endtask

    task automatic tick();
        bit ev, eo, eb;
        int t, n;
        @(posedge iClk_12M);
        cyc++;
        t  = cyc;
        ev = 0;
        eo = 0;
        if (iRst) begin
            model_reset();
        end else if (m_loading) begin
            if (iCoeffWrEn && (int'(iCoeffAddr) < MAX_TAPS)) m_coeff[iCoeffAddr] = iCoeffData;
            if (!iCoeffUpdateFlag) m_loading = 0;
        end else if (t > t_acc && t <= comp_end) begin
            if (iEnSample) eo = 1;
        end else if (iCoeffUpdateFlag) begin
            m_loading = 1;
        end else if (iEnSample) begin
            for (int k = MAX_TAPS - 1; k > 0; k--) m_x[k] = m_x[k-1];
            m_x[0] = iFirIn;
            n = (int'(iNumOfCoeff) > MAX_TAPS) ? MAX_TAPS : int'(iNumOfCoeff);
            y_pend = 0;
            for (int k = 0; k < n; k++) y_pend += m_x[k] * m_coeff[k];
            t_acc    = t;
            comp_end = t + n + 1;
        end
        if (!iRst && t == comp_end) begin
            ev    = 1;
            m_out = fmt_out(y_pend);
        end
        eb = m_loading || (t >= t_acc && t < comp_end);
        #1;
        check("valid", longint'(oFirValid), longint'(ev));
        check("overrun", longint'(oOverrun), longint'(eo));
        check("busy", longint'(oBusy), longint'(eb));
        check("out", longint'(oFirOut), m_out);
        if (oFirValid) begin
            got_q.push_back(longint'(oFirOut));
            valid_cyc_q.push_back(cyc + 1);
        end
        if (oOverrun) ovr_cnt++;
    endtask

    task automatic clear_logs();
        got_q.delete();
        valid_cyc_q.delete();
        strobe_q.delete();
        ovr_cnt = 0;
    endtask

    task automatic enter_load();
        iCoeffUpdateFlag = 1'b1;
        tick();
    endtask

    task automatic wr_coeff(input int a, input int d);
        iCoeffWrEn = 1'b1;
        iCoeffAddr = ADDR_W'(a);
        iCoeffData = COEFF_W'(d);
        tick();
        iCoeffWrEn = 1'b0;
    endtask

    task automatic exit_load();
        iCoeffUpdateFlag = 1'b0;
        tick();
    endtask

    task automatic sample(input int v, input int n, input int gap);
        iEnSample   = 1'b1;
        iFirIn      = DATA_W'(v);
        iNumOfCoeff = CNT_W'(n);
        strobe_q.push_back(cyc + 1);
        tick();
        iEnSample = 1'b0;
        repeat (gap) tick();
    endtask

    int imp_coeff [5] = '{3, -6, 7, -11, 13};
    int imp_exp   [6] = '{3, -6, 7, -11, 13, 0};

    initial begin
        iRst = 1'b1; iEnSample = 1'b0; iFirIn = '0; iCoeffUpdateFlag = 1'b0;
        iCoeffWrEn = 1'b0; iCoeffAddr = '0; iCoeffData = '0; iNumOfCoeff = '0;
        cyc = 0;
        model_reset();
        clear_logs();
        tick();
        tick();
        iRst = 1'b0;
        tick();

        // impulse response
        enter_load();
        for (int i = 0; i < 5; i++) wr_coeff(i, imp_coeff[i]);
        exit_load();
        clear_logs();
        sample(1, 5, 8);
        for (int i = 0; i < 5; i++) sample(0, 5, 8);
        check("imp_count", got_q.size(), 6);
        for (int i = 0; i < 6 && i < got_q.size(); i++) begin
            check("imp_val", got_q[i], imp_exp[i]);
            check("imp_lat", valid_cyc_q[i] - strobe_q[i], 7);
        end

        // saturation / wrap
        enter_load();
        for (int i = 0; i < 4; i++) wr_coeff(i, 32767);
        exit_load();
        clear_logs();
        for (int i = 0; i < 4; i++) sample(3, 4, 6);
        check("sat_count", got_q.size(), 4);
`ifdef FIR_SAT_EN
        if (got_q.size() == 4) check("sat_val", got_q[3], 32767);
`else
        if (got_q.size() == 4) check("wrap_val", got_q[3], -12);
`endif

        // overrun: second strobe two cycles after the first
        clear_logs();
        sample(2, 8, 1);
        sample(1, 8, 12);
        check("ovr_pulses", ovr_cnt, 1);
        check("ovr_valids", got_q.size(), 1);
        if (got_q.size() >= 1) check("ovr_lat", valid_cyc_q[0] - strobe_q[0], 10);

        // N=0 and clamped N=63
        clear_logs();
        sample(3, 0, 4);
        check("n0_count", got_q.size(), 1);
        if (got_q.size() >= 1) begin
            check("n0_lat", valid_cyc_q[0] - strobe_q[0], 2);
            check("n0_val", got_q[0], 0);
        end
        clear_logs();
        sample(1, 63, 44);
        check("n63_count", got_q.size(), 1);
        if (got_q.size() >= 1) check("n63_lat", valid_cyc_q[0] - strobe_q[0], 42);

        // load protocol
        iRst = 1'b1;
        tick();
        iRst = 1'b0;
        iCoeffWrEn = 1'b1; iCoeffAddr = '0; iCoeffData = 16'sd100;
        tick();
        iCoeffWrEn = 1'b0;
        enter_load();
        wr_coeff(45, 55);
        wr_coeff(1, 2);
        exit_load();
        clear_logs();
        sample(1, 2, 5);
        sample(0, 2, 5);
        iEnSample = 1'b1; iFirIn = 3'sd1; iNumOfCoeff = 6'd2;
        tick();
        iEnSample = 1'b0;
        iCoeffUpdateFlag = 1'b1; iCoeffWrEn = 1'b1; iCoeffAddr = '0; iCoeffData = 16'sd5;
        tick();
        iCoeffWrEn = 1'b0;
        repeat (3) tick();
        check("defer_busy", longint'(oBusy), 1);
        iCoeffUpdateFlag = 1'b0;
        repeat (2) tick();
        sample(1, 2, 5);
        check("load_count", got_q.size(), 4);
        if (got_q.size() == 4) begin
            check("load_idle_wr", got_q[0], 0);
            check("load_wr", got_q[1], 2);
            check("load_mac_wr", got_q[3], 2);
        end

        // reset during MAC
        clear_logs();
        iEnSample = 1'b1; iFirIn = 3'sd3; iNumOfCoeff = 6'd8;
        tick();
        iEnSample = 1'b0;
        repeat (2) tick();
        iRst = 1'b1;
        tick();
        check("rst_out", longint'(oFirOut), 0);
        check("rst_busy", longint'(oBusy), 0);
        iRst = 1'b0;
        repeat (12) tick();
        check("rst_no_valid", got_q.size(), 0);

        // random traffic
        for (int i = 0; i < 1500; i++) begin
            iEnSample  = ($urandom_range(0, 99) < 30);
            iFirIn     = DATA_W'($urandom);
            if (iCoeffUpdateFlag) iCoeffUpdateFlag = ($urandom_range(0, 99) >= 30);
            else                  iCoeffUpdateFlag = ($urandom_range(0, 99) < 4);
            iCoeffWrEn = 1'($urandom);
            iCoeffAddr = ADDR_W'($urandom_range(0, 47));
            iCoeffData = COEFF_W'($urandom);
            iNumOfCoeff = ($urandom_range(0, 9) == 0) ? CNT_W'($urandom_range(0, 63))
                                                      : CNT_W'($urandom_range(0, 10));
            iRst = ($urandom_range(0, 299) == 0);
            tick();
        end
        iEnSample = 1'b0; iCoeffUpdateFlag = 1'b0; iCoeffWrEn = 1'b0; iRst = 1'b0;
        repeat (45) tick();

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
